// File: rtl/master_config_seq_if.sv
// master_config_seq_if: front-panel keys, switches and per-master config outputs of master_config_seq.
//   master modport : sequencer side (reads keys/SW/com_done, drives config, strobes and readback)
//   slave  modport : panel/bus side (drives keys/SW/com_done, reads config, strobes and readback)
interface master_config_seq_if #(
    parameter int MASTER_COUNT           = 2,
    parameter int SLAVE_COUNT            = 3,
    parameter int DATA_WIDTH             = 16,
    parameter int ADDR_WIDTH             = 12,
    parameter int MAX_MASTER_WRITE_DEPTH = 16,
    parameter int SW_WIDTH               = 18
);
    localparam int SEL_W = $clog2(SLAVE_COUNT + 1);
    localparam int MW    = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
    localparam int EW    = (MAX_MASTER_WRITE_DEPTH > 1) ? $clog2(MAX_MASTER_WRITE_DEPTH) : 1;
    logic                          jump_stateN;
    logic                          jump_next_addrN;
    logic [SW_WIDTH-1:0]           SW;
    logic                          com_done;
    logic [MASTER_COUNT*SEL_W-1:0] slave_sel;
    logic [MASTER_COUNT-1:0]       rw;
    logic [MASTER_COUNT-1:0]       ext_en;
    logic [MASTER_COUNT*ADDR_WIDTH-1:0] start_addr;
    logic [MASTER_COUNT*ADDR_WIDTH-1:0] end_addr;
    logic                          ext_wr;
    logic [MW-1:0]                 ext_wr_master;
    logic [EW-1:0]                 ext_wr_addr;
    logic [DATA_WIDTH-1:0]         ext_wr_data;
    logic                          config_ready;
    logic                          start_com;
    logic                          rd_req;
    logic [MW-1:0]                 rd_master;
    logic [EW-1:0]                 rd_addr;
    modport master (
        input  jump_stateN, jump_next_addrN, SW, com_done,
        output slave_sel, rw, ext_en, start_addr, end_addr, ext_wr, ext_wr_master, ext_wr_addr,
               ext_wr_data, config_ready, start_com, rd_req, rd_master, rd_addr
    );
    modport slave (
        output jump_stateN, jump_next_addrN, SW, com_done,
        input  slave_sel, rw, ext_en, start_addr, end_addr, ext_wr, ext_wr_master, ext_wr_addr,
               ext_wr_data, config_ready, start_com, rd_req, rd_master, rd_addr
    );
endinterface

// File: rtl/master_config_seq.sv
// master_config_seq: debounced two-key configuration sequencer for MASTER_COUNT bus masters.
//   clk  : system clock, all logic on posedge
//   rstN : synchronous active-low reset
//   bus  : master_config_seq_if.master -- keys (active low), SW, com_done in;
//          slave_sel/rw/ext_en/start_addr/end_addr config, ext_wr strobe, config_ready,
//          start_com pulse and rd_req readback out
// Optional feature macro CFG_READBACK_EN: next_addr press in DONE issues a readback request.
module master_config_seq #(
    parameter int MASTER_COUNT           = 2,
    parameter int SLAVE_COUNT            = 3,
    parameter int DATA_WIDTH             = 16,
    parameter int ADDR_WIDTH             = 12,
    parameter int MAX_MASTER_WRITE_DEPTH = 16,
    parameter int SW_WIDTH               = 18,
    parameter int DEBOUNCE_CYCLES        = 8
) (
    input logic               clk,
    input logic               rstN,
    master_config_seq_if.master bus
);
    localparam int SEL_W = $clog2(SLAVE_COUNT + 1);
    localparam int MW    = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
    localparam int EW    = (MAX_MASTER_WRITE_DEPTH > 1) ? $clog2(MAX_MASTER_WRITE_DEPTH) : 1;
    localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW    = ADDR_WIDTH;
    typedef enum logic [3:0] {SLV_SEL, RW_SEL, EXT_SEL, EXT_LOAD, START_ADDR, END_ADDR, READY, COMM, DONE} state_t;
    state_t                   r_state, w_state;
    logic [1:0]               w_raw_down, r_db_down, r_acc;
    logic [CW-1:0]            r_db_cnt [2];
    logic                     w_js, w_na, w_last;
    logic [MW:0]              w_nx;
    logic [MW-1:0]            r_m, w_m;
    logic [EW-1:0]            r_a, w_a;
    logic [AW-1:0]            w_cur_start, w_sw_addr;
    logic [MASTER_COUNT*SEL_W-1:0] r_slave_sel, w_slave_sel;
    logic [MASTER_COUNT-1:0]  r_rw, w_rw, r_ext_en, w_ext_en;
    logic [MASTER_COUNT*AW-1:0] r_start_addr, w_start_addr, r_end_addr, w_end_addr;
    logic                     r_ext_wr, w_ext_wr, r_start_com, w_start_com, r_rd_req, w_rd_req;
    logic [MW-1:0]            r_ext_wr_master, w_ext_wr_master, r_rd_master, w_rd_master;
    logic [EW-1:0]            r_ext_wr_addr, w_ext_wr_addr, r_rd_addr, w_rd_addr;
    logic [DATA_WIDTH-1:0]    r_ext_wr_data, w_ext_wr_data;
    // Lowest enabled master at index >= from; MSB flags whether one exists.
    function automatic logic [MW:0] next_en(input logic [MASTER_COUNT-1:0] mask, input int from);
        logic [MW:0] res;
        res = '0;
        for (int j = MASTER_COUNT - 1; j >= 0; j--)
            if (j >= from && mask[j]) res = {1'b1, MW'(j)};
        return res;
    endfunction
    assign w_raw_down = {~bus.jump_next_addrN, ~bus.jump_stateN};
    // Debounced level flips after DEBOUNCE_CYCLES consecutive disagreeing samples; r_acc pulses on press only.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_db_down <= '0;
            r_acc     <= '0;
            for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                r_acc[k] <= 1'b0;
                if (w_raw_down[k] == r_db_down[k]) r_db_cnt[k] <= '0;
                else if (r_db_cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db_cnt[k]  <= '0;
                    r_db_down[k] <= w_raw_down[k];
                    r_acc[k]     <= w_raw_down[k];
                end else r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
            end
        end
    end
    // Simultaneous acceptance: state key wins, next_addr is dropped.
    assign w_js        = r_acc[0];
    assign w_na        = r_acc[1] & ~r_acc[0];
    assign w_last      = (r_m == MW'(MASTER_COUNT - 1));
    assign w_cur_start = r_start_addr[r_m*AW +: AW];
    assign w_sw_addr   = bus.SW[AW-1:0];
    always_comb begin
        w_state = r_state;
        w_m = r_m;
        w_a = r_a;
        w_nx = '0;
        w_slave_sel = r_slave_sel;
        w_rw = r_rw;
        w_ext_en = r_ext_en;
        w_start_addr = r_start_addr;
        w_end_addr = r_end_addr;
        w_ext_wr = 1'b0;
        w_ext_wr_master = r_ext_wr_master;
        w_ext_wr_addr = r_ext_wr_addr;
        w_ext_wr_data = r_ext_wr_data;
        w_start_com = 1'b0;
        w_rd_req = 1'b0;
        w_rd_master = r_rd_master;
        w_rd_addr = r_rd_addr;
        case (r_state)
            SLV_SEL: if (w_js) begin
                w_slave_sel = bus.SW[MASTER_COUNT*SEL_W-1:0];
                w_state = RW_SEL;
            end
            RW_SEL: if (w_js) begin
                w_rw = bus.SW[MASTER_COUNT-1:0];
                w_state = EXT_SEL;
            end
            EXT_SEL: if (w_js) begin
                w_ext_en = bus.SW[MASTER_COUNT-1:0];
                w_nx = next_en(bus.SW[MASTER_COUNT-1:0], 0);
                w_m = w_nx[MW] ? w_nx[MW-1:0] : '0;
                w_a = '0;
                w_state = w_nx[MW] ? EXT_LOAD : START_ADDR;
            end
            EXT_LOAD: if (w_js || w_na) begin
                w_ext_wr = 1'b1;
                w_ext_wr_master = r_m;
                w_ext_wr_addr = r_a;
                w_ext_wr_data = bus.SW[DATA_WIDTH-1:0];
                if (w_js) begin
                    w_nx = next_en(r_ext_en, int'(r_m) + 1);
                    w_m = w_nx[MW] ? w_nx[MW-1:0] : '0;
                    w_a = '0;
                    w_state = w_nx[MW] ? EXT_LOAD : START_ADDR;
                end else w_a = (r_a == EW'(MAX_MASTER_WRITE_DEPTH - 1)) ? r_a : r_a + 1'b1;
            end
            START_ADDR: if (w_js) begin
                w_start_addr[r_m*AW +: AW] = w_sw_addr;
                w_m = w_last ? '0 : r_m + 1'b1;
                w_state = w_last ? END_ADDR : START_ADDR;
            end
            END_ADDR: if (w_js) begin
                w_end_addr[r_m*AW +: AW] = (w_sw_addr < w_cur_start) ? w_cur_start : w_sw_addr;
                w_m = w_last ? '0 : r_m + 1'b1;
                w_state = w_last ? READY : END_ADDR;
            end
            READY: if (w_js) begin
                w_start_com = 1'b1;
                w_state = COMM;
            end
            COMM: if (bus.com_done) w_state = DONE;
            DONE: begin
                if (w_js) w_state = SLV_SEL;
`ifdef CFG_READBACK_EN
                if (w_na) begin
                    w_rd_req = 1'b1;
                    w_rd_master = (MASTER_COUNT > 1) ? MW'(bus.SW[SW_WIDTH-1]) : '0;
                    w_rd_addr = bus.SW[EW-1:0];
                end
`else
                w_rd_req = 1'b0;
`endif
            end
            default: w_state = SLV_SEL;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= SLV_SEL;
            r_m <= '0;
            r_a <= '0;
            r_slave_sel <= '0;
            r_rw <= '0;
            r_ext_en <= '0;
            r_start_addr <= '0;
            r_end_addr <= '0;
            r_ext_wr <= 1'b0;
            r_ext_wr_master <= '0;
            r_ext_wr_addr <= '0;
            r_ext_wr_data <= '0;
            r_start_com <= 1'b0;
            r_rd_req <= 1'b0;
            r_rd_master <= '0;
            r_rd_addr <= '0;
        end else begin
            r_state <= w_state;
            r_m <= w_m;
            r_a <= w_a;
            r_slave_sel <= w_slave_sel;
            r_rw <= w_rw;
            r_ext_en <= w_ext_en;
            r_start_addr <= w_start_addr;
            r_end_addr <= w_end_addr;
            r_ext_wr <= w_ext_wr;
            r_ext_wr_master <= w_ext_wr_master;
            r_ext_wr_addr <= w_ext_wr_addr;
            r_ext_wr_data <= w_ext_wr_data;
            r_start_com <= w_start_com;
            r_rd_req <= w_rd_req;
            r_rd_master <= w_rd_master;
            r_rd_addr <= w_rd_addr;
        end
    end
    assign bus.slave_sel     = r_slave_sel;
    assign bus.rw            = r_rw;
    assign bus.ext_en        = r_ext_en;
    assign bus.start_addr    = r_start_addr;
    assign bus.end_addr      = r_end_addr;
    assign bus.ext_wr        = r_ext_wr;
    assign bus.ext_wr_master = r_ext_wr_master;
    assign bus.ext_wr_addr   = r_ext_wr_addr;
    assign bus.ext_wr_data   = r_ext_wr_data;
    assign bus.config_ready  = (r_state == READY);
    assign bus.start_com     = r_start_com;
    assign bus.rd_req        = r_rd_req;
    assign bus.rd_master     = r_rd_master;
    assign bus.rd_addr       = r_rd_addr;
endmodule

// File: tb/tb_master_config_seq.sv
// tb_master_config_seq: randomized scenario bench for master_config_seq against a phase-level reference model.
module tb_master_config_seq;
    localparam int MC = 2, SC = 3, DW = 16, AW = 12, DEPTH = 16, SWW = 18, DEB = 8;
    localparam int SEL_W = 2, EW = 4;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;
    master_config_seq_if #(.MASTER_COUNT(MC), .SLAVE_COUNT(SC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                           .MAX_MASTER_WRITE_DEPTH(DEPTH), .SW_WIDTH(SWW)) bus ();
    master_config_seq #(.MASTER_COUNT(MC), .SLAVE_COUNT(SC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                        .MAX_MASTER_WRITE_DEPTH(DEPTH), .SW_WIDTH(SWW), .DEBOUNCE_CYCLES(DEB))
        dut (.clk(clk), .rstN(rstN), .bus(bus));
    typedef struct packed {logic [0:0] m; logic [EW-1:0] a; logic [DW-1:0] d;} wr_t;
    wr_t obs_wr[$], exp_wr[$];
    logic [EW:0] obs_rd[$], exp_rd[$];
    int obs_sc = 0, exp_sc = 0;
    int errors = 0, checks = 0;
    // Model: ph 0=slave select,1=rw,2=ext select,3=ext load,4=start,5=end,6=ready,7=comm,8=done
    int ph, mm, aa;
    logic [MC*SEL_W-1:0] e_sel;
    logic [MC-1:0] e_rw, e_en;
    logic [MC*AW-1:0] e_start, e_end;
    always @(negedge clk) begin
        if (bus.ext_wr) obs_wr.push_back({bus.ext_wr_master, bus.ext_wr_addr, bus.ext_wr_data});
        if (bus.start_com) obs_sc++;
        if (bus.rd_req) obs_rd.push_back({bus.rd_master, bus.rd_addr});
    end
    function automatic int lowest_from(input logic [MC-1:0] mask, input int from);
        for (int j = from; j < MC; j++) if (mask[j]) return j;
        return -1;
    endfunction
    task automatic model_reset;
        ph = 0; mm = 0; aa = 0;
        e_sel = '0; e_rw = '0; e_en = '0; e_start = '0; e_end = '0;
        obs_wr.delete(); exp_wr.delete(); obs_rd.delete(); exp_rd.delete();
    endtask
    task automatic model_js(input logic [SWW-1:0] sw);
        logic [AW-1:0] s;
        case (ph)
            0: begin e_sel = sw[MC*SEL_W-1:0]; ph = 1; end
            1: begin e_rw = sw[MC-1:0]; ph = 2; end
            2: begin
                e_en = sw[MC-1:0]; aa = 0; mm = lowest_from(e_en, 0);
                ph = (mm < 0) ? 4 : 3;
                if (mm < 0) mm = 0;
            end
            3: begin
                exp_wr.push_back({mm[0], aa[EW-1:0], sw[DW-1:0]});
                aa = 0; mm = lowest_from(e_en, mm + 1);
                ph = (mm < 0) ? 4 : 3;
                if (mm < 0) mm = 0;
            end
            4: begin
                e_start[mm*AW +: AW] = sw[AW-1:0]; mm++;
                if (mm == MC) begin mm = 0; ph = 5; end
            end
            5: begin
                s = e_start[mm*AW +: AW];
                e_end[mm*AW +: AW] = (sw[AW-1:0] > s) ? sw[AW-1:0] : s; mm++;
                if (mm == MC) begin mm = 0; ph = 6; end
            end
            6: begin exp_sc++; ph = 7; end
            8: ph = 0;
            default: ;
        endcase
    endtask
    task automatic model_na(input logic [SWW-1:0] sw);
        if (ph == 3) begin
            exp_wr.push_back({mm[0], aa[EW-1:0], sw[DW-1:0]});
            if (aa < DEPTH - 1) aa++;
        end
`ifdef CFG_READBACK_EN
        if (ph == 8) exp_rd.push_back({sw[SWW-1], sw[EW-1:0]});
`endif
    endtask
    // Full debounced press: DEB low samples, action one cycle later, then DEB+ high to re-arm.
    task automatic press(input bit js, input bit na, input logic [SWW-1:0] sw);
        bus.SW = sw; bus.jump_stateN = ~js; bus.jump_next_addrN = ~na;
        repeat (DEB + 1) @(negedge clk);
        bus.jump_stateN = 1'b1; bus.jump_next_addrN = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        if (js) model_js(sw);
        else if (na) model_na(sw);
    endtask
    task automatic test_reset;
        rstN = 1'b0; bus.jump_stateN = 1'b1; bus.jump_next_addrN = 1'b1; bus.SW = '0; bus.com_done = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        checks++; if (bus.slave_sel !== '0) begin errors++; $display("FAIL reset_slave_sel: got %h expected 0", bus.slave_sel); end
        checks++; if ({bus.rw, bus.ext_en} !== '0) begin errors++; $display("FAIL reset_rw_en: got %h expected 0", {bus.rw, bus.ext_en}); end
        checks++; if ({bus.start_addr, bus.end_addr} !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", {bus.start_addr, bus.end_addr}); end
        checks++; if ({bus.ext_wr, bus.ext_wr_master, bus.ext_wr_addr, bus.ext_wr_data} !== '0) begin errors++; $display("FAIL reset_ext_wr: got %h expected 0", {bus.ext_wr, bus.ext_wr_master, bus.ext_wr_addr, bus.ext_wr_data}); end
        checks++; if ({bus.config_ready, bus.start_com} !== 2'b00) begin errors++; $display("FAIL reset_ready_start: got %b expected 00", {bus.config_ready, bus.start_com}); end
        checks++; if ({bus.rd_req, bus.rd_master, bus.rd_addr} !== '0) begin errors++; $display("FAIL reset_rd: got %h expected 0", {bus.rd_req, bus.rd_master, bus.rd_addr}); end
        rstN = 1'b1;
        repeat (2) @(negedge clk);
    endtask
    task automatic test_sel_rw;
        logic [SWW-1:0] sw;
        sw = SWW'($urandom); sw[3:0] = 4'b1001;
        press(1, 0, sw);
        checks++; if (bus.slave_sel !== e_sel || bus.slave_sel !== 4'b1001) begin errors++; $display("FAIL slave_sel: got %h expected %h", bus.slave_sel, e_sel); end
        sw = SWW'($urandom); sw[1:0] = 2'b10;
        press(1, 0, sw);
        checks++; if (bus.rw !== e_rw || bus.rw !== 2'b10) begin errors++; $display("FAIL rw: got %b expected %b", bus.rw, e_rw); end
    endtask
    task automatic test_debounce;
        logic [SWW-1:0] sw;
        sw = SWW'($urandom); sw[1:0] = 2'b11; bus.SW = sw;
        bus.jump_stateN = 1'b0;
        repeat (5) @(negedge clk);
        bus.jump_stateN = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        checks++; if (bus.ext_en !== e_en) begin errors++; $display("FAIL short_press: ext_en got %b expected %b", bus.ext_en, e_en); end
        for (int i = 0; i < 10; i++) begin
            bus.jump_stateN = 1'b0; @(negedge clk);
            bus.jump_stateN = 1'b1; @(negedge clk);
        end
        repeat (DEB + 2) @(negedge clk);
        checks++; if (bus.ext_en !== e_en) begin errors++; $display("FAIL bounce: ext_en got %b expected %b", bus.ext_en, e_en); end
        press(0, 1, sw);
        checks++; if (obs_wr.size() != 0 || bus.ext_en !== e_en) begin errors++; $display("FAIL next_ignored: writes %0d ext_en %b expected 0 %b", obs_wr.size(), bus.ext_en, e_en); end
        press(1, 0, sw);
        checks++; if (bus.ext_en !== e_en || bus.ext_en !== 2'b11) begin errors++; $display("FAIL ext_en: got %b expected %b", bus.ext_en, e_en); end
    endtask
    task automatic test_ext_load;
        for (int m = 0; m < MC; m++) begin
            for (int i = 0; i < 9; i++) press(0, 1, SWW'($urandom));
            press(1, 0, SWW'($urandom));
        end
        checks++; if (obs_wr.size() != exp_wr.size() || exp_wr.size() != 20) begin errors++; $display("FAIL ext_wr_count: got %0d expected %0d", obs_wr.size(), exp_wr.size()); end
        foreach (exp_wr[i]) if (i < obs_wr.size()) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL ext_wr[%0d]: got %h expected %h", i, obs_wr[i], exp_wr[i]); end
        end
    endtask
    task automatic test_addr;
        logic [SWW-1:0] sw;
        sw = SWW'($urandom); sw[AW-1:0] = 12'd0; press(1, 0, sw);
        sw = SWW'($urandom); sw[AW-1:0] = 12'd7; press(1, 0, sw);
        checks++; if (bus.start_addr !== e_start) begin errors++; $display("FAIL start_addr: got %h expected %h", bus.start_addr, e_start); end
        sw = SWW'($urandom); sw[AW-1:0] = 12'd10; press(1, 0, sw);
        checks++; if (bus.config_ready !== 1'b0) begin errors++; $display("FAIL early_ready: got %b expected 0", bus.config_ready); end
        sw = SWW'($urandom); sw[AW-1:0] = 12'd5; press(1, 0, sw);
        checks++; if (bus.end_addr !== e_end || bus.end_addr !== {12'd7, 12'd10}) begin errors++; $display("FAIL end_addr: got %h expected %h", bus.end_addr, e_end); end
        checks++; if (bus.config_ready !== 1'b1) begin errors++; $display("FAIL config_ready: got %b expected 1", bus.config_ready); end
    endtask
    task automatic test_comm;
        logic [SWW-1:0] sw;
        press(1, 0, SWW'($urandom));
        checks++; if (obs_sc != exp_sc || exp_sc != 1) begin errors++; $display("FAIL start_com: cycles %0d expected %0d", obs_sc, exp_sc); end
        checks++; if (bus.config_ready !== 1'b0) begin errors++; $display("FAIL ready_in_comm: got %b expected 0", bus.config_ready); end
        press(1, 0, SWW'($urandom));
        checks++; if (obs_sc != exp_sc) begin errors++; $display("FAIL comm_key_ignored: start_com cycles %0d expected %0d", obs_sc, exp_sc); end
        bus.com_done = 1'b1;
        repeat (2) @(negedge clk);
        bus.com_done = 1'b0;
        ph = 8;
        sw = SWW'($urandom);
        press(0, 1, sw);
        checks++; if (obs_rd.size() != exp_rd.size()) begin errors++; $display("FAIL rd_count: got %0d expected %0d", obs_rd.size(), exp_rd.size()); end
        foreach (exp_rd[i]) if (i < obs_rd.size()) begin
            checks++;
            if (obs_rd[i] !== exp_rd[i]) begin errors++; $display("FAIL rd[%0d]: got %h expected %h", i, obs_rd[i], exp_rd[i]); end
        end
        press(1, 0, SWW'($urandom));
        sw = SWW'($urandom);
        press(1, 0, sw);
        checks++; if (bus.slave_sel !== e_sel) begin errors++; $display("FAIL reselect: got %h expected %h", bus.slave_sel, e_sel); end
    endtask
    task automatic test_back_to_back;
        logic [SWW-1:0] sw;
        press(1, 0, SWW'($urandom));
        sw = SWW'($urandom); sw[1:0] = 2'b01; press(1, 0, sw);
        obs_wr.delete(); exp_wr.delete();
        for (int i = 0; i < 20; i++) press(0, 1, SWW'($urandom));
        press(1, 1, SWW'($urandom));
        checks++; if (obs_wr.size() != exp_wr.size() || exp_wr.size() != 21) begin errors++; $display("FAIL sat_count: got %0d expected %0d", obs_wr.size(), exp_wr.size()); end
        foreach (exp_wr[i]) if (i < obs_wr.size()) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL sat_wr[%0d]: got %h expected %h", i, obs_wr[i], exp_wr[i]); end
        end
        press(1, 0, SWW'($urandom));
        checks++; if (bus.start_addr !== e_start) begin errors++; $display("FAIL both_keys_start: got %h expected %h", bus.start_addr, e_start); end
    endtask
    task automatic test_reset_mid;
        logic [SWW-1:0] sw;
        rstN = 1'b0; repeat (2) @(negedge clk); rstN = 1'b1; @(negedge clk);
        model_reset();
        press(1, 0, SWW'($urandom));
        press(1, 0, SWW'($urandom));
        sw = SWW'($urandom); sw[1:0] = 2'b10; press(1, 0, sw);
        press(0, 1, SWW'($urandom));
        press(0, 1, SWW'($urandom));
        checks++; if (obs_wr.size() != 2 || obs_wr[0].m !== 1'b1) begin errors++; $display("FAIL mid_pre_writes: got %0d expected 2 on master 1", obs_wr.size()); end
        rstN = 1'b0; repeat (2) @(negedge clk);
        model_reset();
        checks++; if ({bus.slave_sel, bus.rw, bus.ext_en, bus.start_addr, bus.end_addr} !== '0) begin errors++; $display("FAIL mid_reset_cfg: got %h expected 0", {bus.slave_sel, bus.rw, bus.ext_en, bus.start_addr, bus.end_addr}); end
        checks++; if ({bus.ext_wr, bus.ext_wr_addr, bus.ext_wr_data, bus.config_ready, bus.start_com, bus.rd_req} !== '0) begin errors++; $display("FAIL mid_reset_strobes: got %h expected 0", {bus.ext_wr, bus.ext_wr_addr, bus.ext_wr_data, bus.config_ready, bus.start_com, bus.rd_req}); end
        rstN = 1'b1; @(negedge clk);
        sw = SWW'($urandom); sw[3:0] = 4'b0110;
        press(1, 0, sw);
        checks++; if (bus.slave_sel !== e_sel || obs_wr.size() != 0) begin errors++; $display("FAIL mid_reset_fsm: slave_sel %h writes %0d expected %h 0", bus.slave_sel, obs_wr.size(), e_sel); end
    endtask
    initial begin
        test_reset();
        test_sel_rw();
        test_debounce();
        test_ext_load();
        test_addr();
        test_comm();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
